cpu_stage_sequencer: RTL and testbench

- Multi-cycle instruction sequencer for the single-issue RV32I core.
- Steps the datapath through fetch, decode, execute, memory and writeback.
- Gates register-file, data-memory and PC writes produced by the combinational control decoder.
- Owns the valid/ready-style handshakes to instruction and data memory, with a wait timeout that raises a sticky fault.

---
 rtl/cpu_stage_sequencer_pkg.sv | 29 ++
 rtl/cpu_stage_sequencer_wait_timer.sv | 39 +++
 rtl/cpu_stage_sequencer.sv | 145 ++++++++++++++
 tb/tb_cpu_stage_sequencer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_stage_sequencer_pkg.sv
// Shared stage encodings for the RV32I multi-cycle sequencer and any debug/trace logic decoding o_Stage.
package cpu_stage_sequencer_pkg;

   localparam int SEQ_STATE_WIDTH = 3;

   localparam logic [SEQ_STATE_WIDTH-1:0] SEQ_STATE_IDLE      = 3'b000;
   localparam logic [SEQ_STATE_WIDTH-1:0] SEQ_STATE_FETCH     = 3'b001;
   localparam logic [SEQ_STATE_WIDTH-1:0] SEQ_STATE_DECODE    = 3'b010;
   localparam logic [SEQ_STATE_WIDTH-1:0] SEQ_STATE_EXECUTE   = 3'b011;
   localparam logic [SEQ_STATE_WIDTH-1:0] SEQ_STATE_MEMORY    = 3'b100;
   localparam logic [SEQ_STATE_WIDTH-1:0] SEQ_STATE_WRITEBACK = 3'b101;
   localparam logic [SEQ_STATE_WIDTH-1:0] SEQ_STATE_FAULT     = 3'b110;

   typedef enum logic [SEQ_STATE_WIDTH-1:0] {
      ST_IDLE      = SEQ_STATE_IDLE,
      ST_FETCH     = SEQ_STATE_FETCH,
      ST_DECODE    = SEQ_STATE_DECODE,
      ST_EXECUTE   = SEQ_STATE_EXECUTE,
      ST_MEMORY    = SEQ_STATE_MEMORY,
      ST_WRITEBACK = SEQ_STATE_WRITEBACK,
      ST_FAULT     = SEQ_STATE_FAULT
   } seq_state_e;

   // Stages that hold a memory handshake open and are guarded by the wait timer.
   function automatic logic waits_for_ack(seq_state_e s);
      return (s == ST_FETCH) || (s == ST_MEMORY);
   endfunction

endpackage

// File: rtl/cpu_stage_sequencer_wait_timer.sv
// Memory-ack wait timer: down-counter reloaded on stage entry, expires after WAIT_TIMEOUT ack-less cycles.
module sequencer_wait_timer #(
   parameter int WAIT_TIMEOUT = 255,
   parameter int TIMER_WIDTH  = 8
) (
   input  logic i_Clk,
   input  logic i_Reset,
   input  logic i_Clear,
   input  logic i_Count_En,
   input  logic i_Ack,
   output logic o_Expired
);

   localparam logic [TIMER_WIDTH-1:0] TC_INIT = TIMER_WIDTH'(WAIT_TIMEOUT - 1);

   logic [TIMER_WIDTH-1:0] count_q;
   logic [TIMER_WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (i_Clear) begin
         count_d = TC_INIT;
      end else if (i_Count_En && !i_Ack && (count_q != '0)) begin
         count_d = count_q - TIMER_WIDTH'(1);
      end
   end

   always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
         count_q <= TC_INIT;
      end else begin
         count_q <= count_d;
      end
   end

   // Terminal count reached in the last allowed waiting cycle; a same-cycle ack wins.
   assign o_Expired = i_Count_En && !i_Ack && (count_q == '0);

endmodule

// File: rtl/cpu_stage_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer with memory handshakes and a sticky wait-timeout fault.
// Optional perf counters are built only when CPU_SEQ_PERF_COUNTERS_EN is defined.
module cpu_stage_sequencer
   import cpu_stage_sequencer_pkg::*;
#(
   parameter int WAIT_TIMEOUT = 255,
   parameter int TIMER_WIDTH  = 8
) (
   input  logic        i_Clk,
   input  logic        i_Reset,
   input  logic        i_Enable,
   input  logic        i_Instr_Valid,
   input  logic        i_Dmem_Ready,
   input  logic        i_Reg_Write_Enable,
   input  logic        i_Mem_Write_Enable,
   input  logic        i_Mem_Read_Enable,
   output logic        o_Instr_Req,
   output logic        o_Ir_Load,
   output logic        o_Dmem_Req,
   output logic        o_Dmem_Write,
   output logic        o_Reg_File_Write_Enable,
   output logic        o_Pc_Write_Enable,
   output logic        o_Instr_Retired,
   output logic [2:0]  o_Stage,
   output logic        o_Fault,
   output logic [31:0] o_Cycle_Count,
   output logic [31:0] o_Retired_Count
);

   // state     | meaning
   // IDLE      | stopped, waiting for i_Enable
   // FETCH     | instruction request open, waiting for i_Instr_Valid
   // DECODE    | one cycle for the decoder to settle
   // EXECUTE   | one cycle, picks MEMORY / WRITEBACK / retire
   // MEMORY    | data request open, waiting for i_Dmem_Ready
   // WRITEBACK | one-cycle rd commit, always retires
   // FAULT     | memory ack timed out; only reset leaves

   seq_state_e state_q;
   seq_state_e state_d;
   logic       retire;
   logic       timer_clear;
   logic       timer_en;
   logic       timer_ack;
   logic       timer_expired;
   logic       is_mem_op;

   assign is_mem_op = i_Mem_Read_Enable || i_Mem_Write_Enable;

   always_comb begin
      state_d = state_q;
      retire  = 1'b0;
      case (state_q)
         ST_IDLE:      if (i_Enable) state_d = ST_FETCH;
         ST_FETCH: begin
            if (i_Instr_Valid)      state_d = ST_DECODE;
            else if (timer_expired) state_d = ST_FAULT;
         end
         ST_DECODE:    state_d = ST_EXECUTE;
         ST_EXECUTE: begin
            if (is_mem_op)               state_d = ST_MEMORY;
            else if (i_Reg_Write_Enable) state_d = ST_WRITEBACK;
            else                         retire  = 1'b1;
         end
         ST_MEMORY: begin
            // Read and write together is treated as a store.
            if (i_Dmem_Ready) begin
               if (i_Mem_Write_Enable) retire  = 1'b1;
               else                    state_d = ST_WRITEBACK;
            end else if (timer_expired) begin
               state_d = ST_FAULT;
            end
         end
         ST_WRITEBACK: retire  = 1'b1;
         ST_FAULT:     state_d = ST_FAULT;
         default:      state_d = ST_IDLE;
      endcase
      if (retire) state_d = i_Enable ? ST_FETCH : ST_IDLE;
   end

   always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   assign timer_en    = waits_for_ack(state_q);
   assign timer_ack   = (state_q == ST_FETCH) ? i_Instr_Valid : i_Dmem_Ready;
   assign timer_clear = waits_for_ack(state_d) && (state_d != state_q);

   sequencer_wait_timer #(
      .WAIT_TIMEOUT (WAIT_TIMEOUT),
      .TIMER_WIDTH  (TIMER_WIDTH)
   ) u_wait_timer (
      .i_Clk      (i_Clk),
      .i_Reset    (i_Reset),
      .i_Clear    (timer_clear),
      .i_Count_En (timer_en),
      .i_Ack      (timer_ack),
      .o_Expired  (timer_expired)
   );

   assign o_Instr_Req             = (state_q == ST_FETCH);
   assign o_Ir_Load               = (state_q == ST_FETCH) && i_Instr_Valid;
   assign o_Dmem_Req              = (state_q == ST_MEMORY);
   assign o_Dmem_Write            = (state_q == ST_MEMORY) && i_Mem_Write_Enable;
   assign o_Reg_File_Write_Enable = (state_q == ST_WRITEBACK);
   assign o_Pc_Write_Enable       = retire;
   assign o_Instr_Retired         = retire;
   assign o_Stage                 = state_q;
   assign o_Fault                 = (state_q == ST_FAULT);

`ifdef CPU_SEQ_PERF_COUNTERS_EN
   logic [31:0] cycle_cnt_q;
   logic [31:0] cycle_cnt_d;
   logic [31:0] retired_cnt_q;
   logic [31:0] retired_cnt_d;

   always_comb begin
      cycle_cnt_d   = cycle_cnt_q;
      retired_cnt_d = retired_cnt_q;
      if ((state_q != ST_IDLE) && (state_q != ST_FAULT)) cycle_cnt_d = cycle_cnt_q + 32'd1;
      if (retire) retired_cnt_d = retired_cnt_q + 32'd1;
   end

   always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
         cycle_cnt_q   <= '0;
         retired_cnt_q <= '0;
      end else begin
         cycle_cnt_q   <= cycle_cnt_d;
         retired_cnt_q <= retired_cnt_d;
      end
   end

   assign o_Cycle_Count   = cycle_cnt_q;
   assign o_Retired_Count = retired_cnt_q;
`else
   assign o_Cycle_Count   = '0;
   assign o_Retired_Count = '0;
`endif

endmodule

// File: tb/tb_cpu_stage_sequencer.sv
// Self-checking bench for cpu_stage_sequencer: per-instruction expected cycle traces built from stage rules.
module tb_cpu_stage_sequencer;

   localparam int TO = 4;

`ifdef CPU_SEQ_PERF_COUNTERS_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   localparam logic [2:0] S_I = 3'b000, S_F = 3'b001, S_D = 3'b010, S_E = 3'b011,
                          S_M = 3'b100, S_W = 3'b101, S_X = 3'b110;

   localparam logic [7:0] O_IREQ = 8'h80, O_IRL = 8'h40, O_DREQ = 8'h20, O_DWR = 8'h10,
                          O_RFWE = 8'h08, O_RET = 8'h06, O_FLT = 8'h01, O_NONE = 8'h00;

   localparam int K_ALU = 0, K_BR = 1, K_LD = 2, K_ST = 3, K_STRW = 4;

   logic        i_Clk = 1'b0;
   logic        i_Reset = 1'b1;
   logic        i_Enable = 1'b0;
   logic        i_Instr_Valid = 1'b0;
   logic        i_Dmem_Ready = 1'b0;
   logic        i_Reg_Write_Enable = 1'b0;
   logic        i_Mem_Write_Enable = 1'b0;
   logic        i_Mem_Read_Enable = 1'b0;
   logic        o_Instr_Req, o_Ir_Load, o_Dmem_Req, o_Dmem_Write;
   logic        o_Reg_File_Write_Enable, o_Pc_Write_Enable, o_Instr_Retired, o_Fault;
   logic [2:0]  o_Stage;
   logic [31:0] o_Cycle_Count, o_Retired_Count;

   cpu_stage_sequencer #(.WAIT_TIMEOUT(TO), .TIMER_WIDTH(8)) dut (
      .i_Clk                   (i_Clk),
      .i_Reset                 (i_Reset),
      .i_Enable                (i_Enable),
      .i_Instr_Valid           (i_Instr_Valid),
      .i_Dmem_Ready            (i_Dmem_Ready),
      .i_Reg_Write_Enable      (i_Reg_Write_Enable),
      .i_Mem_Write_Enable      (i_Mem_Write_Enable),
      .i_Mem_Read_Enable       (i_Mem_Read_Enable),
      .o_Instr_Req             (o_Instr_Req),
      .o_Ir_Load               (o_Ir_Load),
      .o_Dmem_Req              (o_Dmem_Req),
      .o_Dmem_Write            (o_Dmem_Write),
      .o_Reg_File_Write_Enable (o_Reg_File_Write_Enable),
      .o_Pc_Write_Enable       (o_Pc_Write_Enable),
      .o_Instr_Retired         (o_Instr_Retired),
      .o_Stage                 (o_Stage),
      .o_Fault                 (o_Fault),
      .o_Cycle_Count           (o_Cycle_Count),
      .o_Retired_Count         (o_Retired_Count)
   );

   always #5 i_Clk = ~i_Clk;

   typedef struct packed {
      logic [2:0] stage;
      logic [7:0] outs;
      logic       ack_i;
      logic       ack_d;
      logic       en;
   } step_t;

   step_t       q[$];
   int          n_checks = 0;
   int          n_pass = 0;
   logic [31:0] exp_cyc = '0;
   logic [31:0] exp_ret = '0;

   function automatic logic [7:0] outs_now();
      return {o_Instr_Req, o_Ir_Load, o_Dmem_Req, o_Dmem_Write,
              o_Reg_File_Write_Enable, o_Pc_Write_Enable, o_Instr_Retired, o_Fault};
   endfunction

   function automatic step_t mk(logic [2:0] st, logic [7:0] o, logic ai, logic ad, logic en);
      step_t s;
      s.stage = st; s.outs = o; s.ack_i = ai; s.ack_d = ad; s.en = en;
      return s;
   endfunction

   // Expected trace of one instruction: wf fetch waits, wm memory waits, enable at retire = en_next.
   task automatic build_instr(int kind, int wf, int wm, bit en_next, bit drop);
      bit mem = (kind >= K_LD);
      bit st  = (kind >= K_ST);
      bit wb  = (kind == K_ALU) || (kind == K_LD);
      logic en_mid = drop ? 1'b0 : 1'b1;
      for (int k = 0; k <= wf; k++)
         q.push_back(mk(S_F, O_IREQ | ((k == wf) ? O_IRL : O_NONE), k == wf, 1'b0, 1'b1));
      q.push_back(mk(S_D, O_NONE, 1'b0, 1'b0, 1'b1));
      if (!mem && !wb) q.push_back(mk(S_E, O_RET, 1'b0, 1'b0, en_next));
      else             q.push_back(mk(S_E, O_NONE, 1'b0, 1'b0, en_mid));
      if (mem) begin
         for (int k = 0; k <= wm; k++) begin
            bit last = (k == wm);
            q.push_back(mk(S_M, O_DREQ | (st ? O_DWR : O_NONE) | ((st && last) ? O_RET : O_NONE),
                           1'b0, last, (st && last) ? en_next : en_mid));
         end
      end
      if (wb) q.push_back(mk(S_W, O_RFWE | O_RET, 1'b0, 1'b0, en_next));
   endtask

   task automatic drive_steps(string name, int max_steps);
      int n = 0;
      step_t s;
      while (q.size() > 0 && n < max_steps) begin
         s = q.pop_front();
         i_Instr_Valid = s.ack_i;
         i_Dmem_Ready  = s.ack_d;
         i_Enable      = s.en;
         @(negedge i_Clk);
         n_checks++;
         if ({o_Stage, outs_now()} !== {s.stage, s.outs})
            $display("FAIL %s step %0d: stage/outs got %b/%b want %b/%b",
                     name, n, o_Stage, outs_now(), s.stage, s.outs);
         else n_pass++;
         n_checks++;
         if ({o_Cycle_Count, o_Retired_Count} !== {(PERF ? exp_cyc : 32'd0), (PERF ? exp_ret : 32'd0)})
            $display("FAIL %s_perf step %0d: cyc/ret got %0d/%0d want %0d/%0d", name, n,
                     o_Cycle_Count, o_Retired_Count, PERF ? exp_cyc : 32'd0, PERF ? exp_ret : 32'd0);
         else n_pass++;
         if (s.stage != S_I && s.stage != S_X) exp_cyc++;
         if (s.outs[1]) exp_ret++;
         @(posedge i_Clk); #1;
         n++;
      end
      q.delete();
   endtask

   task automatic set_decoder(int kind);
      i_Reg_Write_Enable = (kind == K_ALU) || (kind == K_LD) ||
                           ((kind >= K_ST) && ($urandom_range(0, 1) == 1));
      i_Mem_Write_Enable = (kind >= K_ST);
      i_Mem_Read_Enable  = (kind == K_LD) || (kind == K_STRW);
   endtask

   task automatic run_instr(string name, int kind, int wf, int wm, bit en_next, bit drop);
      set_decoder(kind);
      build_instr(kind, wf, wm, en_next, drop);
      drive_steps(name, 1000);
   endtask

   task automatic start_from_idle(string name);
      q.push_back(mk(S_I, O_NONE, 1'b0, 1'b0, 1'b1));
      drive_steps(name, 1);
   endtask

   task automatic idle_check(string name, int n);
      for (int k = 0; k < n; k++)
         q.push_back(mk(S_I, O_NONE, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0));
      drive_steps(name, n);
   endtask

   task automatic do_reset(string name);
      i_Reset = 1'b1;
      i_Enable = 1'b0;
      #1;
      n_checks++;
      if ({o_Stage, outs_now(), o_Cycle_Count, o_Retired_Count} !== 75'd0)
         $display("FAIL %s_async: stage/outs got %b/%b cyc %0d ret %0d want all 0",
                  name, o_Stage, outs_now(), o_Cycle_Count, o_Retired_Count);
      else n_pass++;
      @(negedge i_Clk);
      n_checks++;
      if ({o_Stage, outs_now(), o_Cycle_Count, o_Retired_Count} !== 75'd0)
         $display("FAIL %s_held: stage/outs got %b/%b want all 0", name, o_Stage, outs_now());
      else n_pass++;
      @(posedge i_Clk); #1;
      i_Reset = 1'b0;
      exp_cyc = '0;
      exp_ret = '0;
   endtask

   task automatic test_reset();
      start_from_idle("rst_start");
      set_decoder(K_LD);
      build_instr(K_LD, 0, 3, 1'b1, 1'b0);
      drive_steps("rst_pre", 5);
      n_checks++;
      if (o_Dmem_Req !== 1'b1) $display("FAIL rst_inflight: dmem_req got %b want 1", o_Dmem_Req);
      else n_pass++;
      do_reset("rst_mid_mem");
      idle_check("rst_idle", 3);
   endtask

   task automatic test_basic();
      start_from_idle("alu_start");
      run_instr("alu", K_ALU, 0, 0, 1'b1, 1'b0);
      run_instr("load_wait3", K_LD, 0, 3, 1'b1, 1'b0);
      run_instr("store", K_ST, 0, 1, 1'b1, 1'b0);
      run_instr("store_rw", K_STRW, 0, 1, 1'b1, 1'b0);
      run_instr("branch", K_BR, 1, 0, 1'b1, 1'b0);
      run_instr("ack_on_last", K_ALU, TO - 1, 0, 1'b1, 1'b0);
      run_instr("mem_ack_last", K_LD, 0, TO - 1, 1'b0, 1'b0);
      idle_check("basic_idle", 2);
   endtask

   task automatic test_timeout(bit in_mem);
      start_from_idle("to_start");
      set_decoder(K_LD);
      if (in_mem) begin
         q.push_back(mk(S_F, O_IREQ | O_IRL, 1'b1, 1'b0, 1'b1));
         q.push_back(mk(S_D, O_NONE, 1'b0, 1'b0, 1'b1));
         q.push_back(mk(S_E, O_NONE, 1'b0, 1'b0, 1'b1));
      end
      for (int k = 0; k < TO; k++)
         q.push_back(in_mem ? mk(S_M, O_DREQ, 1'b0, 1'b0, 1'b1) : mk(S_F, O_IREQ, 1'b0, 1'b0, 1'b1));
      for (int k = 0; k < 4; k++)
         q.push_back(mk(S_X, O_FLT, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1));
      drive_steps(in_mem ? "timeout_mem" : "timeout_fetch", 1000);
      do_reset("fault_reset");
      idle_check("post_fault_idle", 2);
   endtask

   task automatic test_enable_drop();
      start_from_idle("drop_start");
      run_instr("drop_branch", K_BR, 0, 0, 1'b0, 1'b1);
      idle_check("drop_idle", 3);
      n_checks++;
      if ({o_Cycle_Count, o_Retired_Count} !== {(PERF ? 32'd3 : 32'd0), (PERF ? 32'd1 : 32'd0)})
         $display("FAIL drop_perf: cyc/ret got %0d/%0d", o_Cycle_Count, o_Retired_Count);
      else n_pass++;
   endtask

   task automatic test_random(int n);
      bit running = 1'b0;
      for (int i = 0; i < n; i++) begin
         int  kind = $urandom_range(0, 4);
         bit  en_next = (i != n - 1) && ($urandom_range(0, 4) != 0);
         if (!running) start_from_idle("rand_start");
         run_instr("rand", kind, $urandom_range(0, TO - 1), $urandom_range(0, TO - 1), en_next, 1'b0);
         running = en_next;
         if (!running) idle_check("rand_idle", 2);
      end
   endtask

   initial begin
      @(posedge i_Clk); #1;
      do_reset("por");
      idle_check("por_idle", 2);
      test_reset();
      test_basic();
      test_timeout(1'b0);
      test_timeout(1'b1);
      do_reset("pre_drop");
      test_enable_drop();
      test_random(40);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
